// File: rtl/axi4_lite_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_lite_mem_bridge
//  Purpose  : Turns the CPU native memory port (valid/ready) into single
//             AXI4-lite read or write transactions, one outstanding at a time,
//             with a sticky per-transaction stall watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module axi4_lite_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  // CPU native port
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  // AXI4-lite write address
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  // AXI4-lite write data
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  // AXI4-lite write response
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  // AXI4-lite read address
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  // AXI4-lite read data
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata,
  // Watchdog
  output logic        timeout_err
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;

  // A channel is "ok" once its address/data phase is finished or finishes on
  // this edge; responses are only taken when every request phase is ok, so a
  // response that arrives too early is simply ignored.
  logic w_aw_ok;
  logic w_w_ok;
  logic w_ar_ok;
  logic w_b_take;
  logic w_r_take;

  assign w_aw_ok  = ~mem_axi_awvalid | mem_axi_awready;
  assign w_w_ok   = ~mem_axi_wvalid  | mem_axi_wready;
  assign w_ar_ok  = ~mem_axi_arvalid | mem_axi_arready;
  assign w_b_take = mem_axi_bvalid & mem_axi_bready & w_aw_ok & w_w_ok;
  assign w_r_take = mem_axi_rvalid & mem_axi_rready & w_ar_ok;

  // Transaction sequencer: issues the AXI request, waits for the response, pulses mem_ready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= S_IDLE;
      mem_ready       <= 1'b0;
      mem_rdata       <= 32'd0;
      mem_axi_awvalid <= 1'b0;
      mem_axi_awaddr  <= 32'd0;
      mem_axi_awprot  <= 3'd0;
      mem_axi_wvalid  <= 1'b0;
      mem_axi_wdata   <= 32'd0;
      mem_axi_wstrb   <= 4'd0;
      mem_axi_bready  <= 1'b0;
      mem_axi_arvalid <= 1'b0;
      mem_axi_araddr  <= 32'd0;
      mem_axi_arprot  <= 3'd0;
      mem_axi_rready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          mem_ready <= 1'b0;
          // mem_ready still high means the core has not yet seen completion;
          // its held request must not start a second transaction.
          if (mem_valid && !mem_ready) begin
            if (mem_wstrb != 4'b0000) begin
              mem_axi_awvalid <= 1'b1;
              mem_axi_awaddr  <= mem_addr;
              mem_axi_awprot  <= {mem_instr, 2'b00};
              mem_axi_wvalid  <= 1'b1;
              mem_axi_wdata   <= mem_wdata;
              mem_axi_wstrb   <= mem_wstrb;
              mem_axi_bready  <= 1'b1;
              r_state         <= S_WRITE;
            end else begin
              mem_axi_arvalid <= 1'b1;
              mem_axi_araddr  <= mem_addr;
              mem_axi_arprot  <= {mem_instr, 2'b00};
              mem_axi_rready  <= 1'b1;
              r_state         <= S_READ;
            end
          end
        end
        S_READ: begin
          if (mem_axi_arready) begin
            mem_axi_arvalid <= 1'b0;
          end
          if (w_r_take) begin
            mem_rdata       <= mem_axi_rdata;
            mem_axi_arvalid <= 1'b0;
            mem_axi_rready  <= 1'b0;
            r_state         <= S_DONE;
          end
        end
        S_WRITE: begin
          if (mem_axi_awready) begin
            mem_axi_awvalid <= 1'b0;
          end
          if (mem_axi_wready) begin
            mem_axi_wvalid <= 1'b0;
          end
          if (w_b_take) begin
            mem_axi_awvalid <= 1'b0;
            mem_axi_wvalid  <= 1'b0;
            mem_axi_bready  <= 1'b0;
            r_state         <= S_DONE;
          end
        end
        S_DONE: begin
          mem_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam logic [CW-1:0] C_LIMIT = CW'(TIMEOUT_CYCLES);
      localparam logic [CW-1:0] C_LAST  = CW'(TIMEOUT_CYCLES - 1);
      localparam logic [CW-1:0] C_ONE   = CW'(1);

      logic [CW-1:0] r_wd_cnt;

      // Stall watchdog: counts cycles spent waiting on the slave, flag is sticky
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_wd_cnt    <= '0;
          timeout_err <= 1'b0;
        end else if (r_state == S_IDLE) begin
          r_wd_cnt <= '0;
        end else if ((r_state == S_READ || r_state == S_WRITE) && r_wd_cnt != C_LIMIT) begin
          r_wd_cnt <= r_wd_cnt + C_ONE;
          if (r_wd_cnt == C_LAST) begin
            timeout_err <= 1'b1;
          end
        end
      end
    end else begin : g_no_wdog
      // Watchdog disabled: flag never sets
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          timeout_err <= 1'b0;
        end else begin
          timeout_err <= 1'b0;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi4_lite_mem_bridge
//  Purpose  : Self-checking bench for axi4_lite_mem_bridge: configurable AXI
//             slave with backing memory, word-level reference memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi4_lite_mem_bridge;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic [3:0]  mem_wstrb = 4'd0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_axi_awvalid, mem_axi_awready = 1'b0;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid, mem_axi_wready = 1'b0;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid = 1'b0, mem_axi_bready;
  logic        mem_axi_arvalid, mem_axi_arready = 1'b0;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid = 1'b0, mem_axi_rready;
  logic [31:0] mem_axi_rdata = 32'd0;
  logic        timeout_err;

  always #5 clk = ~clk;

  axi4_lite_mem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
    .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
    .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
    .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
    .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
    .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
    .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
    .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready),
    .mem_axi_rdata(mem_axi_rdata), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave behaviour knobs, written only by the stimulus thread
  bit cfg_rand = 1'b0;
  bit cfg_early_b = 1'b0;
  int cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;

  // Bus monitor: per-edge handshakes, cumulative counts, slave memory writes
  bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
  int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_rdy = 0;
  bit [31:0] smem [16];
  logic [31:0] mon_awaddr, mon_araddr, mon_wdata;
  logic [3:0]  mon_wstrb;
  logic [2:0]  mon_awprot, mon_arprot;
  bit a_have = 1'b0, d_have = 1'b0;

  always @(posedge clk) begin
    aw_hs = mem_axi_awvalid && mem_axi_awready;
    w_hs  = mem_axi_wvalid  && mem_axi_wready;
    b_hs  = mem_axi_bvalid  && mem_axi_bready;
    ar_hs = mem_axi_arvalid && mem_axi_arready;
    r_hs  = mem_axi_rvalid  && mem_axi_rready;
    if (aw_hs) begin n_aw++; mon_awaddr = mem_axi_awaddr; mon_awprot = mem_axi_awprot; a_have = 1'b1; end
    if (w_hs)  begin n_w++;  mon_wdata = mem_axi_wdata; mon_wstrb = mem_axi_wstrb; d_have = 1'b1; end
    if (b_hs)  n_b++;
    if (ar_hs) begin n_ar++; mon_araddr = mem_axi_araddr; mon_arprot = mem_axi_arprot; end
    if (r_hs)  n_r++;
    if (mem_ready) n_rdy++;
    if (!resetn) begin
      a_have = 1'b0;
      d_have = 1'b0;
    end else if (a_have && d_have) begin
      for (int i = 0; i < 4; i++)
        if (mon_wstrb[i]) smem[mon_awaddr[5:2]][8*i +: 8] = mon_wdata[8*i +: 8];
      a_have = 1'b0;
      d_have = 1'b0;
    end
  end

  // AXI slave: drives its outputs on the falling edge
  bit started, aw_done, w_done, b_sent, ar_done, r_sent;
  int c_aw, c_w, c_b, c_ar, c_r;

  always @(negedge clk) begin
    if (!resetn || mem_ready) begin
      started = 0; aw_done = 0; w_done = 0; b_sent = 0; ar_done = 0; r_sent = 0;
      mem_axi_awready = 0; mem_axi_wready = 0; mem_axi_bvalid = 0;
      mem_axi_arready = 0; mem_axi_rvalid = 0;
    end else begin
      if (!started && (mem_axi_awvalid || mem_axi_arvalid)) begin
        started = 1;
        if (cfg_rand) begin
          c_aw = $urandom_range(0, 2); c_w = $urandom_range(0, 2); c_b = $urandom_range(0, 2);
          c_ar = $urandom_range(0, 2); c_r = $urandom_range(0, 2);
        end else begin
          c_aw = cfg_aw; c_w = cfg_w; c_b = cfg_b; c_ar = cfg_ar; c_r = cfg_r;
        end
      end
      if (started) begin
        if (aw_hs) begin mem_axi_awready = 0; aw_done = 1; end
        else if (mem_axi_awvalid && !aw_done && !mem_axi_awready) begin
          if (c_aw == 0) mem_axi_awready = 1; else c_aw--;
        end
        if (w_hs) begin mem_axi_wready = 0; w_done = 1; end
        else if (mem_axi_wvalid && !w_done && !mem_axi_wready) begin
          if (c_w == 0) mem_axi_wready = 1; else c_w--;
        end
        if (cfg_early_b) mem_axi_bvalid = 1;
        else if (b_hs) mem_axi_bvalid = 0;
        else if (aw_done && w_done && !b_sent) begin
          if (c_b == 0) begin mem_axi_bvalid = 1; b_sent = 1; end else c_b--;
        end
        if (ar_hs) begin mem_axi_arready = 0; ar_done = 1; end
        else if (mem_axi_arvalid && !ar_done && !mem_axi_arready) begin
          if (c_ar == 0) mem_axi_arready = 1; else c_ar--;
        end
        if (r_hs) mem_axi_rvalid = 0;
        else if (!r_sent && (ar_done || mem_axi_arready)) begin
          if (c_r == 0) begin
            mem_axi_rvalid = 1; mem_axi_rdata = smem[mem_axi_araddr[5:2]]; r_sent = 1;
          end else c_r--;
        end
      end
    end
  end

  // Reference: word-addressed memory image and the last read data returned
  bit [31:0] model [16];
  logic [31:0] last_rd = 32'd0;

  // One core transaction; checks the whole AXI exchange against the model
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                        input logic instr, output logic [31:0] rd, output int lat, output int to_at,
                        output logic [31:0] h_aw, output logic [31:0] h_w);
    int s_aw = n_aw, s_w = n_w, s_b = n_b, s_ar = n_ar, s_r = n_r, s_rdy = n_rdy;
    logic pv_aw = 0, pv_w = 0, pv_ar = 0;
    logic [31:0] p_awaddr = 0, p_wdata = 0, p_araddr = 0;
    logic [3:0]  p_wstrb = 0;
    logic [2:0]  p_awprot = 0, p_arprot = 0;
    bit stable_ok = 1;
    logic [31:0] exp_rd;
    logic [19:0] hs_got, hs_exp;
    rd = 0; lat = -1; to_at = -1; h_aw = 0; h_w = 0;
    @(negedge clk);
    mem_valid = 1; mem_addr = addr; mem_wdata = wd; mem_wstrb = ws; mem_instr = instr;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (pv_aw && !aw_hs && !(mem_axi_awvalid && mem_axi_awaddr == p_awaddr && mem_axi_awprot == p_awprot)) stable_ok = 0;
      if (pv_w && !w_hs && !(mem_axi_wvalid && mem_axi_wdata == p_wdata && mem_axi_wstrb == p_wstrb)) stable_ok = 0;
      if (pv_ar && !ar_hs && !(mem_axi_arvalid && mem_axi_araddr == p_araddr && mem_axi_arprot == p_arprot)) stable_ok = 0;
      pv_aw = mem_axi_awvalid; p_awaddr = mem_axi_awaddr; p_awprot = mem_axi_awprot;
      pv_w  = mem_axi_wvalid;  p_wdata  = mem_axi_wdata;  p_wstrb  = mem_axi_wstrb;
      pv_ar = mem_axi_arvalid; p_araddr = mem_axi_araddr; p_arprot = mem_axi_arprot;
      if (k < 32) begin h_aw[k] = mem_axi_awvalid; h_w[k] = mem_axi_wvalid; end
      if (timeout_err && to_at < 0) to_at = k;
      if (mem_ready) begin lat = k; rd = mem_rdata; break; end
      // An unruly core changing its request must not disturb the AXI side
      mem_addr = $urandom(); mem_wdata = $urandom();
    end
    check_eq("complete", (lat >= 0), 1);
    if (lat < 0) begin
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "transaction never completed");
    end
    // Request still held for one more edge: must not start a new transaction
    @(posedge clk); #1;
    check_eq("no_reissue", {mem_axi_awvalid, mem_axi_arvalid, mem_ready}, 3'b000);
    mem_valid = 0;
    check_eq("ready_pulses", n_rdy - s_rdy, 1);
    check_eq("axi_stable", stable_ok, 1);
    if (ws != 4'b0000) begin
      hs_exp = {4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
      hs_got = {4'(n_aw - s_aw), 4'(n_w - s_w), 4'(n_b - s_b), 4'(n_ar - s_ar), 4'(n_r - s_r)};
      if (cfg_early_b) hs_got[11:8] = 4'd1;
      check_eq("wr_handshakes", hs_got, hs_exp);
      check_eq("awaddr", mon_awaddr, addr);
      check_eq("awprot", mon_awprot, {instr, 2'b00});
      check_eq("wdata_wstrb", {mon_wdata[27:0], mon_wstrb}, {wd[27:0], ws});
      check_eq("wr_rdata_hold", rd, last_rd);
      for (int i = 0; i < 4; i++)
        if (ws[i]) model[addr[5:2]][8*i +: 8] = wd[8*i +: 8];
    end else begin
      hs_exp = {4'd0, 4'd0, 4'd0, 4'd1, 4'd1};
      hs_got = {4'(n_aw - s_aw), 4'(n_w - s_w), 4'(n_b - s_b), 4'(n_ar - s_ar), 4'(n_r - s_r)};
      check_eq("rd_handshakes", hs_got, hs_exp);
      check_eq("araddr", mon_araddr, addr);
      check_eq("arprot", mon_arprot, {instr, 2'b00});
      exp_rd = model[addr[5:2]];
      check_eq("rdata", rd, exp_rd);
      last_rd = rd;
    end
  endtask

  initial begin
    logic [31:0] rd, h_aw, h_w, ra, rw;
    logic [3:0]  rs;
    int lat, to_at;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid,
                          mem_axi_rready, mem_ready, timeout_err}, 7'd0);
    check_eq("rst_data", mem_rdata | mem_axi_awaddr | mem_axi_araddr | mem_axi_wdata, 32'd0);
    check_eq("rst_prot_strb", {mem_axi_awprot, mem_axi_arprot, mem_axi_wstrb}, 10'd0);
    @(negedge clk);
    resetn = 1;

    // Full write then read back with a zero-wait slave
    do_txn(32'h0000_0010, 32'hA5A5_1234, 4'hF, 1'b0, rd, lat, to_at, h_aw, h_w);
    do_txn(32'h0000_0010, 32'h0, 4'h0, 1'b0, rd, lat, to_at, h_aw, h_w);
    check_eq("rd_full", rd, 32'hA5A5_1234);
    check_eq("rd_latency", lat + 1, 3);

    // Partial byte write
    do_txn(32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, rd, lat, to_at, h_aw, h_w);
    do_txn(32'h0000_0020, 32'h0000_EE00, 4'b0010, 1'b0, rd, lat, to_at, h_aw, h_w);
    do_txn(32'h0000_0020, 32'h0, 4'h0, 1'b0, rd, lat, to_at, h_aw, h_w);
    check_eq("rd_partial", rd, 32'h1122_EE44);

    // Instruction fetch carries the instruction protection bit
    do_txn(32'h0000_0010, 32'h0, 4'h0, 1'b1, rd, lat, to_at, h_aw, h_w);
    check_eq("fetch_arprot", mon_arprot, 3'b100);

    // AW stalled 5 cycles, W immediate, slave raising bvalid prematurely
    cfg_aw = 5; cfg_early_b = 1;
    do_txn(32'h0000_0024, 32'hCAFE_F00D, 4'hF, 1'b0, rd, lat, to_at, h_aw, h_w);
    check_eq("stall_awvalid", h_aw[7:0], 8'b0011_1111);
    check_eq("stall_wvalid", h_w[7:0], 8'b0000_0001);
    check_eq("stall_latency", lat, 7);
    cfg_aw = 0; cfg_early_b = 0;

    // Randomized traffic with small random slave delays
    cfg_rand = 1;
    for (int t = 0; t < 60; t++) begin
      ra = $urandom(); ra[1:0] = 2'b00;
      rw = $urandom();
      rs = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      do_txn(ra, rw, rs, 1'($urandom_range(0, 1)), rd, lat, to_at, h_aw, h_w);
    end
    cfg_rand = 0;
    check_eq("no_false_timeout", timeout_err, 1'b0);

    // Slave withholds rvalid for 20 cycles
    cfg_r = 20;
    do_txn(32'h0000_0010, 32'h0, 4'h0, 1'b0, rd, lat, to_at, h_aw, h_w);
    check_eq("timeout_cycle", to_at, TMO);
    check_eq("late_response", (lat >= 20), 1);
    cfg_r = 0;
    do_txn(32'h0000_0024, 32'h0, 4'h0, 1'b0, rd, lat, to_at, h_aw, h_w);
    check_eq("timeout_sticky", timeout_err, 1'b1);

    // Reset in the middle of a write whose AW is stalled
    cfg_aw = 10;
    @(negedge clk);
    mem_valid = 1; mem_addr = 32'h0000_0030; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'hF; mem_instr = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("pre_rst_awvalid", mem_axi_awvalid, 1'b1);
    #2 resetn = 0;
    #1;
    check_eq("mid_rst_ctrl", {mem_axi_awvalid, mem_axi_wvalid, mem_axi_bready, mem_axi_arvalid,
                              mem_axi_rready, mem_ready, timeout_err}, 7'd0);
    check_eq("mid_rst_data", mem_rdata | mem_axi_awaddr | mem_axi_araddr | mem_axi_wdata, 32'd0);
    check_eq("mid_rst_prot_strb", {mem_axi_awprot, mem_axi_arprot, mem_axi_wstrb}, 10'd0);
    mem_valid = 0;
    cfg_aw = 0;
    last_rd = 32'd0;
    repeat (2) @(negedge clk);
    resetn = 1;
    do_txn(32'h0000_0030, 32'h0, 4'h0, 1'b0, rd, lat, to_at, h_aw, h_w);
    do_txn(32'h0000_0010, 32'h0, 4'h0, 1'b0, rd, lat, to_at, h_aw, h_w);
    check_eq("post_rst_read", rd, model[4]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
